// File: rtl/mc_control.sv
// Multicycle processor control FSM: sequences fetch/decode/execute states and
// drives datapath enables, with a bounded memory wait and a sticky timeout trap.
module mc_control #(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] OP,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       IR_WE,
    output logic       PC_WE,
    output logic [1:0] PC_src,
    output logic       Reg_WE,
    output logic       DM_WE,
    output logic       MEM_to_REG,
    output logic       REG_Dst,
    output logic       ALU_src_A,
    output logic [1:0] ALU_src_B,
    output logic [1:0] ALU_OP,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11,
        ILLEGAL = 4'd12,
        ERR     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam int CW = (MAX_WAIT > 16) ? $clog2(MAX_WAIT) : 4;

    state_t        state_q;
    state_t        state_next;
    state_t        cur_state;
    logic [CW-1:0] wait_cnt;
    logic          is_mem;
    logic          timeout;
    logic          ready_q;
    logic          unused_funct;

    // funct is routed to the ALU decoder elsewhere; it has no effect here.
    assign unused_funct = ^funct;

    assign is_mem  = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    assign timeout = is_mem && !mem_ready && (wait_cnt == CW'(MAX_WAIT - 1));

    // NOTE: non-blocking assignments keep every register update on the same
    // clock edge independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            wait_cnt <= '0;
        end else begin
            state_q <= state_next;
            if (state_next != state_q)
                wait_cnt <= '0;
            else if (is_mem && !mem_ready)
                wait_cnt <= wait_cnt + CW'(1);
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state_q;
        unique case (state_q)
            FETCH:   if (mem_ready) state_next = DECODE;
                     else if (timeout) state_next = ERR;
            DECODE: begin
                unique case (OP)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXEC;
                    OP_BEQ:       state_next = BRANCH;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JUMP;
                    default:      state_next = ILLEGAL;
                endcase
            end
            MEMADR:  state_next = (OP == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (mem_ready) state_next = MEMWB;
                     else if (timeout) state_next = ERR;
            MEMWR:   if (mem_ready) state_next = FETCH;
                     else if (timeout) state_next = ERR;
            EXEC:    state_next = ALUWB;
            ADDIEX:  state_next = ADDIWB;
            MEMWB, ALUWB, BRANCH, ADDIWB, JUMP, ILLEGAL: state_next = FETCH;
            ERR:     state_next = ERR;
            default: state_next = ERR;
        endcase
    end

    // While rst is high the outputs look like FETCH with no memory response,
    // so no write enable or completion pulse can escape during reset.
    assign cur_state = rst ? FETCH : state_q;
    assign ready_q   = mem_ready && !rst;
    assign state     = cur_state;

    always_comb begin
        mem_req    = 1'b0;
        IorD       = 1'b0;
        IR_WE      = 1'b0;
        PC_WE      = 1'b0;
        PC_src     = 2'b00;
        Reg_WE     = 1'b0;
        DM_WE      = 1'b0;
        MEM_to_REG = 1'b0;
        REG_Dst    = 1'b0;
        ALU_src_A  = 1'b0;
        ALU_src_B  = 2'b00;
        ALU_OP     = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        err        = 1'b0;
        unique case (cur_state)
            FETCH: begin
                mem_req   = 1'b1;
                ALU_src_B = 2'b01;
                IR_WE     = ready_q;
                PC_WE     = ready_q;
            end
            DECODE:  ALU_src_B = 2'b11;
            MEMADR, ADDIEX: begin
                ALU_src_A = 1'b1;
                ALU_src_B = 2'b10;
            end
            MEMRD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                Reg_WE     = 1'b1;
                MEM_to_REG = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                mem_req    = 1'b1;
                IorD       = 1'b1;
                DM_WE      = 1'b1;
                instr_done = ready_q;
            end
            EXEC: begin
                ALU_src_A = 1'b1;
                ALU_OP    = 2'b10;
            end
            ALUWB: begin
                Reg_WE     = 1'b1;
                REG_Dst    = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                ALU_src_A  = 1'b1;
                ALU_OP     = 2'b01;
                PC_src     = 2'b01;
                PC_WE      = zero;
                instr_done = 1'b1;
            end
            ADDIWB: begin
                Reg_WE     = 1'b1;
                instr_done = 1'b1;
            end
            JUMP: begin
                PC_WE      = 1'b1;
                PC_src     = 2'b10;
                instr_done = 1'b1;
            end
            ILLEGAL: illegal_op = 1'b1;
            ERR:     err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: per-cycle stimulus plans, expected
// output vectors queued from a reference model and compared at the falling edge.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] OP;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, IorD, IR_WE, PC_WE, Reg_WE, DM_WE, MEM_to_REG, REG_Dst, ALU_src_A;
    logic       instr_done, illegal_op, err;
    logic [1:0] PC_src, ALU_src_B, ALU_OP;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       r;
        logic       rdy;
        logic       z;
        logic [5:0] op;
        logic [3:0] st;
    } stim_t;

    stim_t       plan[$];
    logic [21:0] sb[$];
    logic [21:0] obs;
    logic [21:0] exp_v;

    mc_control #(.MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst), .OP(OP), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .IorD(IorD), .IR_WE(IR_WE), .PC_WE(PC_WE), .PC_src(PC_src),
        .Reg_WE(Reg_WE), .DM_WE(DM_WE), .MEM_to_REG(MEM_to_REG), .REG_Dst(REG_Dst),
        .ALU_src_A(ALU_src_A), .ALU_src_B(ALU_src_B), .ALU_OP(ALU_OP),
        .instr_done(instr_done), .illegal_op(illegal_op), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    assign obs = {state, mem_req, IorD, IR_WE, PC_WE, PC_src, Reg_WE, DM_WE, MEM_to_REG,
                  REG_Dst, ALU_src_A, ALU_src_B, ALU_OP, instr_done, illegal_op, err};

    // Reference outputs per state, written from the controller's output table.
    function automatic logic [21:0] model(input logic [3:0] st_in, input logic rdy_in,
                                          input logic z, input logic r);
        logic [3:0] st = st_in;
        logic rdy = rdy_in;
        logic mr = 0, iod = 0, ir = 0, pcw = 0, rw = 0, dw = 0, m2r = 0, rd = 0, sa = 0;
        logic dn = 0, il = 0, er = 0;
        logic [1:0] ps = 0, sb_ = 0, ao = 0;
        if (r) begin
            st  = 4'd0;
            rdy = 1'b0;
        end
        case (st)
            4'd0:  begin mr = 1; sb_ = 2'b01; ir = rdy; pcw = rdy; end
            4'd1:  sb_ = 2'b11;
            4'd2:  begin sa = 1; sb_ = 2'b10; end
            4'd3:  begin mr = 1; iod = 1; end
            4'd4:  begin rw = 1; m2r = 1; dn = 1; end
            4'd5:  begin mr = 1; iod = 1; dw = 1; dn = rdy; end
            4'd6:  begin sa = 1; ao = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; dn = 1; end
            4'd8:  begin sa = 1; ao = 2'b01; ps = 2'b01; pcw = z; dn = 1; end
            4'd9:  begin sa = 1; sb_ = 2'b10; end
            4'd10: begin rw = 1; dn = 1; end
            4'd11: begin pcw = 1; ps = 2'b10; dn = 1; end
            4'd12: il = 1;
            4'd13: er = 1;
            default: ;
        endcase
        return {st, mr, iod, ir, pcw, ps, rw, dw, m2r, rd, sa, sb_, ao, dn, il, er};
    endfunction

    task automatic add(input logic r, input logic rdy, input logic z, input logic [5:0] op,
                       input logic [3:0] st);
        stim_t s;
        s.r = r; s.rdy = rdy; s.z = z; s.op = op; s.st = st;
        plan.push_back(s);
    endtask

    task automatic test_reset();
        add(1, 1, 0, 6'h00, 0);
        add(1, 1, 1, 6'h00, 0);
        foreach (plan[i]) begin
            rst = plan[i].r; mem_ready = plan[i].rdy; zero = plan[i].z; OP = plan[i].op;
            funct = 6'($urandom);
            sb.push_back(model(plan[i].st, plan[i].rdy, plan[i].z, plan[i].r));
            @(negedge clk);
            exp_v = sb.pop_front(); total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL reset row %0d: got %h want %h", i, obs, exp_v);
            end
            @(posedge clk); #1;
        end
        plan.delete();
    endtask

    task automatic test_rtype();
        add(0, 1, 0, 6'b000000, 0); add(0, 1, 0, 6'b000000, 1);
        add(0, 1, 0, 6'b000000, 6); add(0, 1, 0, 6'b000000, 7);
        foreach (plan[i]) begin
            rst = plan[i].r; mem_ready = plan[i].rdy; zero = plan[i].z; OP = plan[i].op;
            funct = 6'($urandom);
            sb.push_back(model(plan[i].st, plan[i].rdy, plan[i].z, plan[i].r));
            @(negedge clk);
            exp_v = sb.pop_front(); total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL rtype row %0d: got %h want %h", i, obs, exp_v);
            end
            @(posedge clk); #1;
        end
        plan.delete();
    endtask

    task automatic test_lw_wait();
        add(0, 1, 0, 6'b100011, 0); add(0, 1, 0, 6'b100011, 1); add(0, 1, 0, 6'b100011, 2);
        add(0, 0, 0, 6'b100011, 3); add(0, 0, 0, 6'b100011, 3); add(0, 0, 0, 6'b100011, 3);
        add(0, 1, 0, 6'b100011, 3); add(0, 0, 0, 6'b100011, 4);
        foreach (plan[i]) begin
            rst = plan[i].r; mem_ready = plan[i].rdy; zero = plan[i].z; OP = plan[i].op;
            funct = 6'($urandom);
            sb.push_back(model(plan[i].st, plan[i].rdy, plan[i].z, plan[i].r));
            @(negedge clk);
            exp_v = sb.pop_front(); total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL lw_wait row %0d: got %h want %h", i, obs, exp_v);
            end
            @(posedge clk); #1;
        end
        plan.delete();
    endtask

    task automatic test_sw();
        add(0, 1, 0, 6'b101011, 0); add(0, 0, 0, 6'b101011, 1); add(0, 1, 0, 6'b101011, 2);
        add(0, 0, 0, 6'b101011, 5); add(0, 1, 0, 6'b101011, 5);
        foreach (plan[i]) begin
            rst = plan[i].r; mem_ready = plan[i].rdy; zero = plan[i].z; OP = plan[i].op;
            funct = 6'($urandom);
            sb.push_back(model(plan[i].st, plan[i].rdy, plan[i].z, plan[i].r));
            @(negedge clk);
            exp_v = sb.pop_front(); total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL sw row %0d: got %h want %h", i, obs, exp_v);
            end
            @(posedge clk); #1;
        end
        plan.delete();
    endtask

    task automatic test_branch_jump_addi();
        add(0, 1, 0, 6'b000100, 0); add(0, 1, 0, 6'b000100, 1); add(0, 1, 0, 6'b000100, 8);
        add(0, 1, 1, 6'b000100, 0); add(0, 1, 1, 6'b000100, 1); add(0, 1, 1, 6'b000100, 8);
        add(0, 1, 0, 6'b000010, 0); add(0, 1, 0, 6'b000010, 1); add(0, 1, 0, 6'b000010, 11);
        add(0, 1, 0, 6'b001000, 0); add(0, 1, 0, 6'b001000, 1); add(0, 1, 0, 6'b001000, 9);
        add(0, 1, 0, 6'b001000, 10);
        foreach (plan[i]) begin
            rst = plan[i].r; mem_ready = plan[i].rdy; zero = plan[i].z; OP = plan[i].op;
            funct = 6'($urandom);
            sb.push_back(model(plan[i].st, plan[i].rdy, plan[i].z, plan[i].r));
            @(negedge clk);
            exp_v = sb.pop_front(); total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL br_j_addi row %0d: got %h want %h", i, obs, exp_v);
            end
            @(posedge clk); #1;
        end
        plan.delete();
    endtask

    task automatic test_illegal();
        add(0, 1, 0, 6'b111111, 0); add(0, 1, 0, 6'b111111, 1); add(0, 1, 0, 6'b111111, 12);
        foreach (plan[i]) begin
            rst = plan[i].r; mem_ready = plan[i].rdy; zero = plan[i].z; OP = plan[i].op;
            funct = 6'($urandom);
            sb.push_back(model(plan[i].st, plan[i].rdy, plan[i].z, plan[i].r));
            @(negedge clk);
            exp_v = sb.pop_front(); total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL illegal row %0d: got %h want %h", i, obs, exp_v);
            end
            @(posedge clk); #1;
        end
        plan.delete();
    endtask

    // mem_ready arriving on the last tolerated wait cycle must still win.
    task automatic test_ready_at_limit();
        for (int k = 0; k < 14; k++) add(0, 0, 0, 6'b000000, 0);
        add(0, 1, 0, 6'b000000, 0); add(0, 1, 0, 6'b000000, 1);
        add(0, 1, 0, 6'b000000, 6); add(0, 1, 0, 6'b000000, 7);
        foreach (plan[i]) begin
            rst = plan[i].r; mem_ready = plan[i].rdy; zero = plan[i].z; OP = plan[i].op;
            funct = 6'($urandom);
            sb.push_back(model(plan[i].st, plan[i].rdy, plan[i].z, plan[i].r));
            @(negedge clk);
            exp_v = sb.pop_front(); total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL ready_limit row %0d: got %h want %h", i, obs, exp_v);
            end
            @(posedge clk); #1;
        end
        plan.delete();
    endtask

    task automatic test_rst_mid_write();
        add(0, 1, 0, 6'b101011, 0); add(0, 1, 0, 6'b101011, 1); add(0, 1, 0, 6'b101011, 2);
        add(1, 1, 0, 6'b101011, 0);
        foreach (plan[i]) begin
            rst = plan[i].r; mem_ready = plan[i].rdy; zero = plan[i].z; OP = plan[i].op;
            funct = 6'($urandom);
            sb.push_back(model(plan[i].st, plan[i].rdy, plan[i].z, plan[i].r));
            @(negedge clk);
            exp_v = sb.pop_front(); total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL rst_mid row %0d: got %h want %h", i, obs, exp_v);
            end
            @(posedge clk); #1;
        end
        plan.delete();
    endtask

    task automatic test_timeout();
        for (int k = 0; k < 15; k++) add(0, 0, 0, 6'b000000, 0);
        add(0, 1, 0, 6'b000000, 13); add(0, 0, 1, 6'b000000, 13); add(0, 1, 0, 6'b000000, 13);
        add(1, 0, 0, 6'b000000, 0);  add(0, 0, 0, 6'b000000, 0);
        add(0, 1, 0, 6'b000000, 0);  add(0, 1, 0, 6'b000000, 1);
        foreach (plan[i]) begin
            rst = plan[i].r; mem_ready = plan[i].rdy; zero = plan[i].z; OP = plan[i].op;
            funct = 6'($urandom);
            sb.push_back(model(plan[i].st, plan[i].rdy, plan[i].z, plan[i].r));
            @(negedge clk);
            exp_v = sb.pop_front(); total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL timeout row %0d: got %h want %h", i, obs, exp_v);
            end
            @(posedge clk); #1;
        end
        plan.delete();
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; OP = 6'h00; funct = 6'h00;
        #1;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw();
        test_branch_jump_addi();
        test_illegal();
        test_ready_at_limit();
        test_rst_mid_write();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter MAX_WAIT, default 15: memory wait cycles tolerated before the error state.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 OP  in  6  opcode field, sampled only in DECODE.
REQ-005 funct  in  6  function field, passed as-is; the controller does not decode it.
REQ-006 zero  in  1  ALU zero flag, used in BRANCH only.
REQ-007 mem_ready  in  1  memory accepted or completed the current request.
REQ-008 mem_req  out  1  memory access request.
REQ-009 IorD  out  1  memory address select: 0 = PC, 1 = ALU result.
REQ-010 IR_WE  out  1  instruction register write enable.
REQ-011 PC_WE  out  1  PC write enable.
REQ-012 PC_src  out  2  PC source: 00 = ALU, 01 = ALU-out register, 10 = jump target.
REQ-013 Reg_WE, DM_WE, MEM_to_REG, REG_Dst  out  1 each  register-file and memory controls.
REQ-014 ALU_src_A  out  1  ALU A operand: 0 = PC, 1 = register.
REQ-015 ALU_src_B  out  2  ALU B operand: 00 = reg, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-016 ALU_OP  out  2  ALU operation: 00 = add, 01 = sub, 10 = funct-defined.
REQ-017 instr_done  out  1  one-cycle pulse in the final cycle of an instruction.
REQ-018 illegal_op  out  1  one-cycle pulse for an unsupported opcode.
REQ-019 err  out  1  sticky memory-timeout flag.
REQ-020 state  out  4  current state encoding, for debug.

Function
REQ-021 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ILLEGAL=12, ERR=13.
REQ-022 The state register is registered; outputs are combinational from state, except the terms that are qualified by mem_ready or zero.
REQ-023 Any output not listed for a state is 0.
REQ-024 FETCH: mem_req=1, IorD=0, ALU_src_A=0, ALU_src_B=01, ALU_OP=00, PC_src=00.
REQ-025 FETCH: IR_WE = PC_WE = mem_ready; go to DECODE when mem_ready=1, else stay.
REQ-026 DECODE: ALU_src_A=0, ALU_src_B=11, ALU_OP=00.
REQ-027 DECODE next state: OP 100011 or 101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; any other -> ILLEGAL.
REQ-028 MEMADR: ALU_src_A=1, ALU_src_B=10, ALU_OP=00; next MEMRD if OP=100011, else MEMWR.
REQ-029 MEMRD: mem_req=1, IorD=1; go to MEMWB on mem_ready.
REQ-030 MEMWB: Reg_WE=1, MEM_to_REG=1, REG_Dst=0, instr_done=1; next FETCH.
REQ-031 MEMWR: mem_req=1, IorD=1, DM_WE=1; on mem_ready, instr_done=1 and next FETCH.
REQ-032 EXEC: ALU_src_A=1, ALU_src_B=00, ALU_OP=10; next ALUWB.
REQ-033 ALUWB: Reg_WE=1, REG_Dst=1, MEM_to_REG=0, instr_done=1; next FETCH.
REQ-034 BRANCH: ALU_src_A=1, ALU_src_B=00, ALU_OP=01, PC_src=01, PC_WE=zero, instr_done=1; next FETCH.
REQ-035 ADDIEX: ALU_src_A=1, ALU_src_B=10, ALU_OP=00; next ADDIWB.
REQ-036 ADDIWB: Reg_WE=1, REG_Dst=0, MEM_to_REG=0, instr_done=1; next FETCH.
REQ-037 JUMP: PC_WE=1, PC_src=10, instr_done=1; next FETCH.
REQ-038 ILLEGAL: illegal_op=1, no writes; next FETCH.
REQ-039 wait_cnt (4+ bits) clears on entry to any memory state (FETCH, MEMRD, MEMWR) and increments each cycle that state holds with mem_ready=0.
REQ-040 If mem_ready=0 while wait_cnt==MAX_WAIT-1, next state is ERR.
REQ-041 A mem_ready sampled in the same cycle as the timeout wins: the normal transition is taken.
REQ-042 ERR: err=1, all other outputs 0; the only exit is rst.
REQ-043 Zero-wait latency in cycles: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3.
REQ-044 mem_ready is ignored outside the memory states.

Reset
REQ-045 rst=1 at a clock edge forces state=FETCH, wait_cnt=0 and err=0, regardless of the current state, including mid-access and ERR.
REQ-046 While rst is asserted, all outputs are 0 except the FETCH outputs that do not depend on mem_ready.
REQ-047 PC_WE, IR_WE and instr_done are never asserted in a cycle where rst=1.

Verification
REQ-048 mem_ready tied 1, OP=000000 -> states 0,1,6,7; Reg_WE=1 and REG_Dst=1 in cycle 4; instr_done pulses once.
REQ-049 OP=100011, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with Reg_WE=1 and MEM_to_REG=1.
REQ-050 OP=000100 with zero=0, then zero=1 -> PC_WE=0, then PC_WE=1, both in BRANCH.
REQ-051 OP=111111 -> ILLEGAL for 1 cycle with illegal_op=1, Reg_WE=DM_WE=0, then FETCH.
REQ-052 mem_ready held 0 in FETCH -> ERR after exactly MAX_WAIT (15) cycles, err stays 1; rst then returns FETCH with err=0.
REQ-053 rst asserted during MEMWR with mem_ready=1 -> next state FETCH, no instr_done pulse.
